// File: rtl/alu_seq_if.sv
// Request/result bundle between the sequencer FSM (master) and alu_seq (slave).
interface alu_seq_if #(
    parameter int N = 8
);
    logic         start;
    logic [4:0]   aluop;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] Y;
    logic         carry;
    logic         zero;
    logic         neg;
    logic         busy;
    logic         done;

    modport master (output start, aluop, A, B, input Y, carry, zero, neg, busy, done);
    modport slave  (input start, aluop, A, B, output Y, carry, zero, neg, busy, done);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU with internal carry/zero/neg flags and serial shift-by-N.
// Define MUL_EN to add the N-cycle shift-add multiply on opcode 0x12 (otherwise 0x12 acts as ZERO).
module alu_seq #(
    parameter int N = 8
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int CB = $clog2(N);
    localparam int CW = CB + 1;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [4:0] OP_SHL = 5'h10;
    localparam logic [4:0] OP_SHR = 5'h11;
`ifdef MUL_EN
    localparam logic [4:0] OP_MUL = 5'h12;
    localparam logic [CW-1:0] CNT_MUL = CW'(N);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_MUL = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1} state_t;
`endif

    state_t        state_r, state_s;
    logic [N-1:0]  y_r, y_s;
    logic          carry_r, c_s;
    logic          zero_r, neg_r, busy_r, done_r, upd_s;
    logic [N-1:0]  work_r, work_s, shift_s;
    logic [CW-1:0] cnt_r, cnt_s, sh_cnt_s;
    logic          left_r, left_s, sout_s, is_shift_s;
    logic [N:0]    res_s;
`ifdef MUL_EN
    logic [N-1:0]  a_r, a_s, hi_r, hi_s;
    logic [N:0]    sum_s;
`endif

    // Classic 16 ops as an (N+1)-bit result: bit N becomes the carry/borrow flag.
    function automatic logic [N:0] classic_f(input logic [3:0] op, input logic [N-1:0] a,
                                             input logic [N-1:0] b, input logic c);
        logic [N:0] r;
        case (op)
            4'h0:    r = {(N+1){1'b0}};
            4'h1:    r = {1'b0, a};
            4'h2:    r = {1'b0, a} + {{N{1'b0}}, 1'b1};
            4'h3:    r = {1'b0, a} - {{N{1'b0}}, 1'b1};
            4'h4:    r = {a, 1'b0};
            4'h5:    r = {a[0], 1'b0, a[N-1:1]};
            4'h6:    r = {a, c};
            4'h7:    r = {a[0], c, a[N-1:1]};
            4'h8:    r = {1'b0, a | b};
            4'h9:    r = {1'b0, a & b};
            4'hA:    r = {1'b0, a ^ b};
            4'hB:    r = {1'b0, b};
            4'hC:    r = {1'b0, a} + {1'b0, b};
            4'hD:    r = {1'b0, a} - {1'b0, b};
            4'hE:    r = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
            4'hF:    r = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, c};
            default: r = {(N+1){1'b0}};
        endcase
        return r;
    endfunction

    assign sh_cnt_s   = {1'b0, bus.B[CB-1:0]};
    assign is_shift_s = (bus.aluop == OP_SHL) || (bus.aluop == OP_SHR);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= S_IDLE;
        else       state_r <= state_s;
    end

    // Next-state decode: only shifts with a nonzero count and MUL leave IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.start && is_shift_s && (sh_cnt_s != {CW{1'b0}})) begin
                    state_s = S_SHIFT;
`ifdef MUL_EN
                end else if (bus.start && (bus.aluop == OP_MUL)) begin
                    state_s = S_MUL;
`endif
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (cnt_r == CNT_ONE) state_s = S_IDLE;
                else                  state_s = S_SHIFT;
            end
`ifdef MUL_EN
            S_MUL: begin
                if (cnt_r == CNT_ONE) state_s = S_IDLE;
                else                  state_s = S_MUL;
            end
`endif
            default: state_s = S_IDLE;
        endcase
    end

    // Datapath/output decode: work registers advance while busy, Y/flags change only when upd_s
    always_comb begin
        work_s  = work_r;
        cnt_s   = cnt_r;
        left_s  = left_r;
        upd_s   = 1'b0;
        y_s     = y_r;
        c_s     = carry_r;
        res_s   = classic_f(bus.aluop[3:0], bus.A, bus.B, carry_r);
        shift_s = left_r ? {work_r[N-2:0], 1'b0} : {1'b0, work_r[N-1:1]};
        sout_s  = left_r ? work_r[N-1] : work_r[0];
`ifdef MUL_EN
        a_s     = a_r;
        hi_s    = hi_r;
        sum_s   = {1'b0, hi_r} + (work_r[0] ? {1'b0, a_r} : {(N+1){1'b0}});
`endif
        case (state_r)
            S_IDLE: begin
                if (!bus.start) begin
                    upd_s = 1'b0;
                end else if (!bus.aluop[4]) begin
                    upd_s = 1'b1;
                    y_s   = res_s[N-1:0];
                    c_s   = res_s[N];
                end else if (is_shift_s) begin
                    if (sh_cnt_s == {CW{1'b0}}) begin
                        upd_s = 1'b1;
                        y_s   = bus.A;
                    end else begin
                        work_s = bus.A;
                        cnt_s  = sh_cnt_s;
                        left_s = (bus.aluop == OP_SHL);
                    end
`ifdef MUL_EN
                end else if (bus.aluop == OP_MUL) begin
                    a_s    = bus.A;
                    work_s = bus.B;
                    hi_s   = {N{1'b0}};
                    cnt_s  = CNT_MUL;
`endif
                end else begin
                    upd_s = 1'b1;
                    y_s   = {N{1'b0}};
                    c_s   = 1'b0;
                end
            end
            S_SHIFT: begin
                work_s = shift_s;
                cnt_s  = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    upd_s = 1'b1;
                    y_s   = shift_s;
                    c_s   = sout_s;
                end else begin
                    upd_s = 1'b0;
                end
            end
`ifdef MUL_EN
            // {hi,work} shifts right each step; work ends up holding the low product half
            S_MUL: begin
                hi_s   = sum_s[N:1];
                work_s = {sum_s[0], work_r[N-1:1]};
                cnt_s  = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    upd_s = 1'b1;
                    y_s   = {sum_s[0], work_r[N-1:1]};
                    c_s   = |sum_s[N:1];
                end else begin
                    upd_s = 1'b0;
                end
            end
`endif
            default: upd_s = 1'b0;
        endcase
    end

    // Result, flag, handshake and work registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_r     <= {N{1'b0}};
            carry_r <= 1'b0;
            zero_r  <= 1'b1;
            neg_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            work_r  <= {N{1'b0}};
            cnt_r   <= {CW{1'b0}};
            left_r  <= 1'b0;
`ifdef MUL_EN
            a_r     <= {N{1'b0}};
            hi_r    <= {N{1'b0}};
`endif
        end else begin
            busy_r <= (state_s != S_IDLE);
            done_r <= upd_s;
            work_r <= work_s;
            cnt_r  <= cnt_s;
            left_r <= left_s;
`ifdef MUL_EN
            a_r    <= a_s;
            hi_r   <= hi_s;
`endif
            if (upd_s) begin
                y_r     <= y_s;
                carry_r <= c_s;
                zero_r  <= (y_s == {N{1'b0}});
                neg_r   <= y_s[N-1];
            end
        end
    end

    assign bus.Y     = y_r;
    assign bus.carry = carry_r;
    assign bus.zero  = zero_r;
    assign bus.neg   = neg_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (N=8): vector table with a done-driven scoreboard,
// plus hand sequences for ignored start, back-to-back start and reset mid-operation.
module tb_alu_seq;
    localparam int N  = 8;
    localparam int NV = 25;

    typedef struct {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       c;
        logic       z;
        logic       n;
        int         lat;
    } vec_t;

    typedef struct {
        logic [7:0] y;
        logic       c;
        logic       z;
        logic       n;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   failed = 0;
    int   n_done = 0;
    exp_t sb_q[$];
    vec_t tbl[NV];

    alu_seq_if #(.N(N)) bus ();
    alu_seq #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result
    always @(negedge clk) begin
        if (!reset && bus.done === 1'b1) begin
            exp_t e;
            n_done++;
            chk("done_without_busy", {31'd0, bus.busy}, 32'd0);
            chk("done_expected", {31'd0, (sb_q.size() != 0)}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_Y", {24'd0, bus.Y}, {24'd0, e.y});
                chk("sb_carry", {31'd0, bus.carry}, {31'd0, e.c});
                chk("sb_zero", {31'd0, bus.zero}, {31'd0, e.z});
                chk("sb_neg", {31'd0, bus.neg}, {31'd0, e.n});
            end
        end
    end

    task automatic run_op(input vec_t v, input int idx);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.aluop = v.op;
        bus.A     = v.a;
        bus.B     = v.b;
        sb_q.push_back('{v.y, v.c, v.z, v.n});
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            chk($sformatf("vec%0d busy", idx), {31'd0, bus.busy}, 32'd1);
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("vec%0d latency", idx), cyc, v.lat);
        @(negedge clk);
        chk($sformatf("vec%0d done_width", idx), {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int d0;

        tbl[0]  = '{5'h0C, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 0};  // ADD
        tbl[1]  = '{5'h0E, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 0};  // ADC
        tbl[2]  = '{5'h0D, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, 0};  // SUB
        tbl[3]  = '{5'h0F, 8'h05, 8'h01, 8'h03, 1'b0, 1'b0, 1'b0, 0};  // SBB
        tbl[4]  = '{5'h10, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 3};  // SHL 3
        tbl[5]  = '{5'h02, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 0};  // INC
        tbl[6]  = '{5'h10, 8'h55, 8'h08, 8'h55, 1'b1, 1'b0, 1'b0, 0};  // SHL 0
        tbl[7]  = '{5'h11, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1'b0, 1};  // SHR 1
        tbl[8]  = '{5'h06, 8'h80, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 0};  // ROL
        tbl[9]  = '{5'h07, 8'h01, 8'h00, 8'h80, 1'b1, 1'b0, 1'b1, 0};  // ROR
        tbl[10] = '{5'h1F, 8'h55, 8'h66, 8'h00, 1'b0, 1'b1, 1'b0, 0};  // ext ZERO
        tbl[11] = '{5'h03, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 0};  // DEC
        tbl[12] = '{5'h0A, 8'hF0, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0, 0};  // XOR
        tbl[13] = '{5'h05, 8'h03, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 0};  // LSR
        tbl[14] = '{5'h04, 8'hC0, 8'h00, 8'h80, 1'b1, 1'b0, 1'b1, 0};  // ASL
`ifdef MUL_EN
        tbl[15] = '{5'h12, 8'h10, 8'h20, 8'h00, 1'b1, 1'b1, 1'b0, 8};
        tbl[16] = '{5'h12, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 1'b1, 8};
`else
        tbl[15] = '{5'h12, 8'h10, 8'h20, 8'h00, 1'b0, 1'b1, 1'b0, 0};
        tbl[16] = '{5'h12, 8'h0D, 8'h0B, 8'h00, 1'b0, 1'b1, 1'b0, 0};
`endif
        tbl[17] = '{5'h09, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0, 0};  // AND
        tbl[18] = '{5'h0B, 8'h00, 8'h7E, 8'h7E, 1'b0, 1'b0, 1'b0, 0};  // LOAD_B
        tbl[19] = '{5'h08, 8'h80, 8'h01, 8'h81, 1'b0, 1'b0, 1'b1, 0};  // OR
        tbl[20] = '{5'h01, 8'h42, 8'h00, 8'h42, 1'b0, 1'b0, 1'b0, 0};  // LOAD_A
        tbl[21] = '{5'h02, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 0};  // INC
        tbl[22] = '{5'h11, 8'h18, 8'h04, 8'h01, 1'b1, 1'b0, 1'b0, 4};  // SHR 4
        tbl[23] = '{5'h00, 8'hAA, 8'hBB, 8'h00, 1'b0, 1'b1, 1'b0, 0};  // ZERO
        tbl[24] = '{5'h03, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 0};  // DEC

        bus.start = 1'b0;
        bus.aluop = 5'h00;
        bus.A     = 8'h00;
        bus.B     = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_Y", {24'd0, bus.Y}, 32'd0);
        chk("rst_carry", {31'd0, bus.carry}, 32'd0);
        chk("rst_zero", {31'd0, bus.zero}, 32'd1);
        chk("rst_neg", {31'd0, bus.neg}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_op(tbl[i], i);

        // SHL by 7 with an ADD pulse and operand changes while busy
        d0 = n_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.aluop = 5'h10;
        bus.A     = 8'h03;
        bus.B     = 8'h07;
        sb_q.push_back('{8'h80, 1'b1, 1'b0, 1'b1});
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            chk("shl7 hold_Y", {24'd0, bus.Y}, {24'd0, tbl[NV-1].y});
            bus.start = (cyc == 2) ? 1'b1 : 1'b0;
            if (cyc == 2) begin
                bus.aluop = 5'h0C;
                bus.A     = 8'h01;
                bus.B     = 8'h01;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk("shl7 latency", cyc, 7);
        repeat (4) @(negedge clk);
        chk("shl7 single_done", n_done - d0, 1);

        // Back-to-back: new start accepted in the done cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.aluop = 5'h11;
        bus.A     = 8'h02;
        bus.B     = 8'h01;
        sb_q.push_back('{8'h01, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b first_latency", cyc, 1);
        bus.start = 1'b1;
        bus.aluop = 5'h0C;
        bus.A     = 8'h02;
        bus.B     = 8'h03;
        sb_q.push_back('{8'h05, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b second_done", {31'd0, bus.done}, 32'd1);
        chk("b2b second_Y", {24'd0, bus.Y}, 32'h05);

        run_op(tbl[NV-1], NV);

        // Reset two cycles into a long op: immediate clear, no done afterwards
        @(negedge clk);
        bus.start = 1'b1;
`ifdef MUL_EN
        bus.aluop = 5'h12;
        bus.A     = 8'h10;
        bus.B     = 8'h20;
`else
        bus.aluop = 5'h10;
        bus.A     = 8'h01;
        bus.B     = 8'h07;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("abort busy_before", {31'd0, bus.busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort Y", {24'd0, bus.Y}, 32'd0);
        chk("abort carry", {31'd0, bus.carry}, 32'd0);
        chk("abort zero", {31'd0, bus.zero}, 32'd1);
        chk("abort neg", {31'd0, bus.neg}, 32'd0);
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        chk("abort done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        d0 = n_done;
        repeat (12) @(negedge clk);
        chk("abort no_done", n_done - d0, 0);
        chk("queue_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, multi-cycle successor to the combinational 8-bit ALU, parametrised in width. It keeps the 16 single-cycle opcodes and adds internal carry/zero/negative flag registers, so ADC/SBB/ROL/ROR chains need no external carry wiring. It also adds multi-cycle shift-by-N and an optional shift-add multiply behind a start/busy/done handshake. It sits between the register file and the accumulator in the teaching CPUs and is driven directly by the sequencer FSM.

## Interface
- N, default 8, data width; legal range 2..32, power of two.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on clk edge only when busy=0.
- aluop  input  5  operation; [4]=0 selects the classic 16 ops 0x0-0xF, [4]=1 selects extended ops.
- A  input  N  operand A, latched at accept.
- B  input  N  operand B, latched at accept.
- Y  output  N  result register.
- carry  output  1  carry/borrow flag register.
- zero  output  1  flag register, set when Y==0.
- neg  output  1  flag register, equal to Y[N-1].
- busy  output  1  high while a multi-cycle op runs.
- done  output  1  one-cycle pulse when Y and the flags have been updated.

## Operation
- Classic ops 0x00-0x0F keep their encodings: ZERO, LOAD_A, INC, DEC, ASL, LSR, ROL, ROR, OR, AND, XOR, LOAD_B, ADD, SUB, ADC, SBB.
  - Each classic op computes an (N+1)-bit result R. Y=R[N-1:0] and carry=R[N].
  - The carry input of ROL, ROR, ADC and SBB is the internal carry flag.
  - ZERO, LOAD_A, LOAD_B, OR, AND and XOR clear carry.
  - INC of all-ones sets carry. DEC of zero sets carry (borrow).
- Extended ops:
  - 0x10 SHL: shift A left by c = B[$clog2(N)-1:0], one bit per cycle. carry = last bit shifted out.
  - 0x11 SHR: logical right shift by c. carry = last bit shifted out.
  - 0x12 MUL (MUL_EN only): unsigned A*B, shift-add, one bit of B per cycle. Y = low N bits; carry = 1 if the high N bits are nonzero.
  - 0x13-0x1F: behave as ZERO.
- zero and neg update with every completed op, derived from the new Y.
- FSM states: IDLE, SHIFT, MUL.
  - IDLE + start: single-cycle op (or SHL/SHR with c=0) → stay in IDLE. SHL/SHR with c≥1 → SHIFT. MUL → MUL.
  - SHIFT: decrement the count each cycle; at count 0 → IDLE.
  - MUL: run N iterations, then → IDLE.
- Operand latching and result holding:
  - Operands and the extended opcode are latched internally at accept.
  - Y and the flags hold their previous values while busy and update only on the completing edge.
  - A SHL/SHR with c=0 gives Y=A and leaves carry unchanged.
- start while busy=1 is ignored; no queueing.
- start in the same cycle as done (busy=0) is accepted normally, allowing back-to-back operation.
- Reset values: Y=0, carry=0, zero=1, neg=0, busy=0, done=0, state IDLE.
- Reset asserted mid-operation aborts the op immediately. No done pulse follows.

## Timing
- Accept edge k is the edge where start=1 and busy=0.
- Single-cycle op: Y and the flags update on edge k. done=1 for the cycle after edge k. busy stays 0.
- SHL/SHR with c≥1: busy=1 after edge k. Shifts happen on edges k+1..k+c. After edge k+c, Y and the flags are updated, busy=0 and done=1. done therefore appears c cycles after a single-cycle done would.
- MUL: busy=1 after edge k. Iterations run on edges k+1..k+N. After edge k+N, done=1 and busy=0.
- done is always exactly one cycle wide and never coincides with busy=1.

## Configuration
- MUL_EN defined: opcode 0x12 is the N-cycle multiply and the MUL state exists.
- MUL_EN undefined: no multiplier logic or MUL state. Opcode 0x12 behaves as ZERO: single-cycle, Y=0, carry=0, zero=1.

## Test plan
- Carry chain (N=8):
  - ADD A=0xFF B=0x01 → Y=0x00, carry=1, zero=1, done one cycle later.
  - Then ADC A=0x00 B=0x00 → Y=0x01, carry=0, zero=0.
- Borrow: SUB A=0x00 B=0x01 → Y=0xFF, carry=1, neg=1. Then SBB A=0x05 B=0x01 → Y=0x03, carry=0.
- SHL A=0x81 B=0x03 → busy for 3 cycles, then Y=0x08, carry=0, done pulse. A follow-up SHL with B=0x00 → Y=A, carry unchanged, single-cycle done.
- MUL A=0x10 B=0x20 (MUL_EN) → busy 8 cycles, then Y=0x00, carry=1, zero=1. Without MUL_EN → single-cycle Y=0x00, carry=0.
- start pulsed with ADD during a running SHL by 7 → ignored; the SHL result is unaffected and only one done pulse occurs.
- reset asserted 2 cycles into a MUL → outputs immediately Y=0, carry=0, zero=1, busy=0, with no done pulse afterward.
